demux_scheduler: RTL
====================

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 The block SHALL have one parameter: DWELL, default 1, cycles each channel stays selected (legal 1..16).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to send one word; sampled only in IDLE.
REQ-005 din  input  4  data word; bit i is the value routed to channel i.
REQ-006 ch_en  input  4  channel enable mask; bit i=1 means channel i is visited.
REQ-007 A  output  1  serial data to the downstream 1-to-4 demultiplexer.
REQ-008 S0  output  1  select bit 0 to the demultiplexer.
REQ-009 S1  output  1  select bit 1 to the demultiplexer; channel index = {S1,S0}.
REQ-010 busy  output  1  high while a word is being sent.
REQ-011 done  output  1  single-cycle pulse marking completion of a word.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 IDLE: start=1 at an edge SHALL capture din and ch_en into internal registers at that edge.
REQ-015 IDLE with start=1 and captured mask nonzero: next state SEND, sel = lowest-index enabled channel, dwell counter = 0.
REQ-016 IDLE with start=1 and mask = 4'b0000: next state DONE directly; A, S0, S1 stay 0.
REQ-017 SEND: {S1,S0} SHALL equal sel and A SHALL equal captured din[sel]; busy=1.
REQ-018 SEND: each selected channel SHALL be held for exactly DWELL consecutive cycles.
REQ-019 On the last dwell cycle, sel SHALL advance to the next higher enabled channel, skipping disabled ones, with no gap cycle.
REQ-020 On the last dwell cycle of the highest enabled channel, next state SHALL be DONE.
REQ-021 DONE: done=1, busy=0, A=0, {S1,S0}=2'b00 for exactly one cycle; next state IDLE unconditionally.
REQ-022 IDLE: A=0, {S1,S0}=2'b00, busy=0, done=0.
REQ-023 start SHALL be ignored in SEND and DONE; din/ch_en changes after capture SHALL NOT affect the word in flight.
REQ-024 Latency: first channel visible on outputs the cycle after the start-sampling edge; done asserts the cycle after the final channel's last dwell cycle.
REQ-025 Total SEND cycles per word SHALL be DWELL x (number of set bits in captured ch_en).
REQ-026 sel SHALL never wrap from 3 to 0 within one word.
REQ-027 The dwell counter SHALL be wide enough for DWELL-1 and reset to 0 on every channel change.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force state IDLE, A=0, S0=0, S1=0, busy=0, done=0, and clear sel, dwell counter and captured registers.
REQ-029 rst asserted mid-SEND SHALL abort the word; no done pulse SHALL follow.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first rising edge with rst low.

Verification
REQ-031 DWELL=1, din=4'b1011, ch_en=4'hF, 1-cycle start -> over 4 consecutive cycles ({S1,S0},A) = (0,1),(1,1),(2,0),(3,1), busy=1; then done=1 for 1 cycle; then IDLE.
REQ-032 DWELL=3, din=4'b0110, ch_en=4'hF -> each channel held 3 cycles, A = 0,0,0,1,1,1,1,1,1,0,0,0; busy high for 12 cycles; done on cycle 13.
REQ-033 DWELL=1, din=4'b0001, ch_en=4'b0101 -> (0,1) then (2,0), 2 SEND cycles, then done pulse.
REQ-034 ch_en=4'b0000, start=1 -> DONE next cycle, done=1 one cycle, busy never asserts, A/S stay 0.
REQ-035 start held high and din toggled every cycle during SEND -> output sequence matches captured din, no restart until after DONE; a start held through DONE is accepted on return to IDLE.
REQ-036 rst pulsed asynchronously (between edges) during channel 2 of a word -> all outputs 0 before next edge; no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/demux_scheduler.sv
// Serialises a captured 4-bit word onto one data line while steering a 1-to-4 demux,
// holding each enabled channel for DWELL cycles before moving to the next higher one.
module demux_scheduler #(
   parameter int DWELL = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] din,
   input  logic [3:0] ch_en,
   output logic       A,
   output logic       S0,
   output logic       S1,
   output logic       busy,
   output logic       done
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    din_q, din_d;
   logic [3:0]    mask_q, mask_d;
   logic          a_q, a_d;
   logic [1:0]    s_q, s_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [1:0]    firstSel;
   logic [1:0]    nextSel;
   logic          nextFound;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         din_q   <= '0;
         mask_q  <= '0;
         a_q     <= 1'b0;
         s_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         mask_q  <= mask_d;
         a_q     <= a_d;
         s_q     <= s_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Descending scans so the lowest qualifying index is the one left standing.
   always_comb begin
      firstSel  = '0;
      nextSel   = sel_q;
      nextFound = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (ch_en[i]) begin
            firstSel = 2'(i);
         end
         if (mask_q[i] && (i > int'(sel_q))) begin
            nextSel   = 2'(i);
            nextFound = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      mask_d  = mask_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               din_d  = din;
               mask_d = ch_en;
               cnt_d  = '0;
               if (|ch_en) begin
                  state_d = SEND;
                  sel_d   = firstSel;
               end else begin
                  state_d = DONE;
                  sel_d   = '0;
               end
            end
         end
         SEND: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (nextFound) begin
                  sel_d = nextSel;
               end else begin
                  state_d = DONE;
                  sel_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are computed from the next state so they land in registers aligned with it.
   always_comb begin
      busy_d = (state_d == SEND);
      done_d = (state_d == DONE);
      s_d    = busy_d ? sel_d : 2'b00;
      a_d    = busy_d ? din_d[sel_d] : 1'b0;
   end

   assign A    = a_q;
   assign S0   = s_q[0];
   assign S1   = s_q[1];
   assign busy = busy_q;
   assign done = done_q;

endmodule
